// File: rtl/fb_scanout.sv
// VGA-style raster scanout: free-running h/v counters advanced on the pixel tick,
// upscaled framebuffer reads, and registered colour/sync outputs one tick behind the counters.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module fb_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_ce,
    output logic                        fb_re,
    output logic [`DISP_ADDR_WIDTH-1:0] fb_raddr,
    input  logic [31:0]                 fb_rdata,
    output logic [3:0]                  vga_r,
    output logic [3:0]                  vga_g,
    output logic [3:0]                  vga_b,
    output logic                        vga_hs,
    output logic                        vga_vs,
    output logic                        frame_start
);

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int AW       = `DISP_ADDR_WIDTH;
    localparam int HW       = $clog2(H_TOT);
    localparam int VW       = $clog2(V_TOT);
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [AW-1:0] r_raddr;
    logic          r_re_d;
    logic [11:0]   r_pix;
    logic          r_act_d;
    logic [HW-1:0] r_h_d;
    logic [VW-1:0] r_v_d;
    logic [3:0]    r_r;
    logic [3:0]    r_g;
    logic [3:0]    r_b;
    logic          r_hs;
    logic          r_vs;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_active;
    logic          w_re;
    logic [31:0]   w_addr_calc;
    logic [AW-1:0] w_addr;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_unused;

    assign w_h_last = (r_h_cnt == HW'(H_TOT - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOT - 1));
    assign w_active = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign w_re     = pix_ce && w_active && !reset;

    // Dropping SCALE_SHIFT bits from each counter repeats pixels and lines.
    assign w_addr_calc = ((32'(r_v_cnt) >> SCALE_SHIFT) * 32'(FB_W))
                       + (32'(r_h_cnt) >> SCALE_SHIFT);
    assign w_addr      = w_addr_calc[AW-1:0];

    assign w_hs_n = !((r_h_d >= HW'(HS_FIRST)) && (r_h_d <= HW'(HS_LAST)));
    assign w_vs_n = !((r_v_d >= VW'(VS_FIRST)) && (r_v_d <= VW'(VS_LAST)));

    assign w_unused = ^{fb_rdata[31:12], w_addr_calc};

    // The read strobe and address belong to the tick cycle itself; the address is held afterwards.
    assign fb_re       = w_re;
    assign fb_raddr    = w_re ? w_addr : r_raddr;
    assign frame_start = pix_ce && !reset && (r_h_cnt == '0) && (r_v_cnt == '0);

    assign vga_r  = r_r;
    assign vga_g  = r_g;
    assign vga_b  = r_b;
    assign vga_hs = r_hs;
    assign vga_vs = r_vs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_raddr <= '0;
            r_re_d  <= 1'b0;
            r_pix   <= '0;
            r_act_d <= 1'b0;
            r_h_d   <= '0;
            r_v_d   <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
        end else begin
            r_re_d <= w_re;
            if (r_re_d) begin
                r_pix <= fb_rdata[11:0];
            end
            if (w_re) begin
                r_raddr <= w_addr;
            end
            // Ticks are >=2 clk apart, so the pixel read on tick k is held before tick k+1.
            if (pix_ce) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + HW'(1);
                end
                r_act_d <= w_active;
                r_h_d   <= r_h_cnt;
                r_v_d   <= r_v_cnt;
                r_r     <= r_act_d ? r_pix[11:8] : 4'h0;
                r_g     <= r_act_d ? r_pix[7:4]  : 4'h0;
                r_b     <= r_act_d ? r_pix[3:0]  : 4'h0;
                r_hs    <= w_hs_n;
                r_vs    <= w_vs_n;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized-spacing bench for fb_scanout with a tick-indexed raster model and framebuffer memory.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module tb_fb_scanout;
  localparam int H_ACTIVE = 32;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 16;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam int SS       = 1;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W     = H_ACTIVE >> SS;
  localparam int FB_H     = V_ACTIVE >> SS;
  localparam int AW       = `DISP_ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_ce = 1'b0;
  logic          fb_re;
  logic [AW-1:0] fb_raddr;
  logic [31:0]   fb_rdata = '0;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, frame_start;

  fb_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SCALE_SHIFT(SS)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .fb_re(fb_re), .fb_raddr(fb_raddr), .fb_rdata(fb_rdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  // clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] fb_mem [FB_W*FB_H];
  logic [31:0] rd_next = '0;

  // reference model state: raster position of the next tick and the previous tick's position
  int          m_h, m_v;
  bit          p_valid, p_act;
  int          p_h, p_v;
  logic [11:0] p_pix;
  logic [AW-1:0] m_last_addr;
  logic [3:0]  e_r, e_g, e_b;
  logic        e_hs, e_vs;
  int          ticks_since_fs, hs_lo, vs_lo;
  bit          fs_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (h=%0d v=%0d t=%0t)", tag, got, exp, m_h, m_v, $time);
    end
  endtask

  // framebuffer: data appears one clk after the strobe; upper bits are junk
  always @(negedge clk) begin
    fb_rdata = rd_next;
    if (fb_re === 1'b1)
      rd_next = {20'($urandom), fb_mem[int'(fb_raddr)]};
    else
      rd_next = $urandom;
  end

  function automatic bit in_rng(input int x, input int lo, input int n);
    return (x >= lo) && (x < lo + n);
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0;
    p_valid = 0; p_act = 0; p_h = 0; p_v = 0; p_pix = '0;
    m_last_addr = '0;
    e_r = '0; e_g = '0; e_b = '0; e_hs = 1'b1; e_vs = 1'b1;
    fs_seen = 0; ticks_since_fs = 0; hs_lo = 0; vs_lo = 0;
  endtask

  // one clk cycle; called at posedge+1, drives pix_ce, checks strobe side at negedge and outputs after the edge
  task automatic step(input bit ce);
    bit act, tick;
    int addr;
    pix_ce = ce;
    @(negedge clk);
    act  = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
    addr = (m_v >> SS) * FB_W + (m_h >> SS);
    tick = ce && !reset;
    check("fb_re", 32'(fb_re), 32'(tick && act));
    if (tick && act) m_last_addr = AW'(addr);
    check("fb_raddr", 32'(fb_raddr), 32'(m_last_addr));
    check("frame_start", 32'(frame_start), 32'(tick && m_h == 0 && m_v == 0));
    if (frame_start === 1'b1) begin
      if (fs_seen) begin
        check("frame_period", ticks_since_fs, H_TOT * V_TOT);
        check("hs_low_ticks", hs_lo, H_SYNC * V_TOT);
        check("vs_low_ticks", vs_lo, V_SYNC * H_TOT);
      end
      fs_seen = 1; ticks_since_fs = 0; hs_lo = 0; vs_lo = 0;
    end
    @(posedge clk); #1;
    if (reset) begin
      model_reset();
    end else if (ce) begin
      e_r  = (p_valid && p_act) ? p_pix[11:8] : 4'h0;
      e_g  = (p_valid && p_act) ? p_pix[7:4]  : 4'h0;
      e_b  = (p_valid && p_act) ? p_pix[3:0]  : 4'h0;
      e_hs = !(p_valid && in_rng(p_h, H_ACTIVE + H_FP, H_SYNC));
      e_vs = !(p_valid && in_rng(p_v, V_ACTIVE + V_FP, V_SYNC));
      p_valid = 1; p_act = act; p_h = m_h; p_v = m_v;
      p_pix = act ? fb_mem[addr] : 12'h000;
      m_h = m_h + 1;
      if (m_h == H_TOT) begin
        m_h = 0;
        m_v = (m_v + 1) % V_TOT;
      end
      ticks_since_fs++;
      if (vga_hs === 1'b0) hs_lo++;
      if (vga_vs === 1'b0) vs_lo++;
    end
    check("vga_r", 32'(vga_r), 32'(e_r));
    check("vga_g", 32'(vga_g), 32'(e_g));
    check("vga_b", 32'(vga_b), 32'(e_b));
    check("vga_hs", 32'(vga_hs), 32'(e_hs));
    check("vga_vs", 32'(vga_vs), 32'(e_vs));
  endtask

  // n pixel ticks with 1..3 idle clk between them
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < FB_W * FB_H; i++) fb_mem[i] = 12'($urandom);
    model_reset();
    @(posedge clk); #1;

    // reset wins over a pixel tick
    reset = 1'b1;
    step(1'b1);
    step(1'b0);
    step(1'b1);
    reset = 1'b0;
    step(1'b0);

    // more than one full frame so the frame period and sync counts are checked
    run_ticks(H_TOT * V_TOT + 60);

    // long stall mid-line, then resume
    for (int i = 0; i < 100; i++) step(1'b0);
    run_ticks(200);

    // solid red framebuffer for a full frame
    for (int i = 0; i < FB_W * FB_H; i++) fb_mem[i] = 12'hF00;
    for (int i = 0; i < 4; i++) step(1'b0);
    run_ticks(H_TOT * V_TOT + 10);

    // reset in the middle of line 10, with a read possibly in flight
    for (int i = 0; i < H_TOT * V_TOT && !(m_v == 10 && m_h == 13); i++) begin
      step(1'b1);
      step(1'b0);
    end
    check("reach_line10", m_v, 10);
    step(1'b1);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    step(1'b0);
    for (int i = 0; i < FB_W * FB_H; i++) fb_mem[i] = 12'($urandom);
    step(1'b0);
    run_ticks(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 The module SHALL expose parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL expose parameters H_FP 16, H_SYNC 96, H_BP 48, the horizontal front porch, sync and back porch in pixels.
REQ-003 The module SHALL expose parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 The module SHALL expose parameters V_FP 10, V_SYNC 2, V_BP 33, the vertical front porch, sync and back porch in lines.
REQ-005 The module SHALL expose parameter SCALE_SHIFT, default 1, the log2 upscale factor; the framebuffer is FB_W = H_ACTIVE>>SCALE_SHIFT wide.
REQ-006 The module SHALL have port clk, input, 1 bit, the sole clock.
REQ-007 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The module SHALL have port pix_ce, input, 1 bit, the pixel-tick enable; consecutive ticks are at least 2 clk apart.
REQ-009 The module SHALL have port fb_re, output, 1 bit, the framebuffer read strobe.
REQ-010 The module SHALL have port fb_raddr, output, `DISP_ADDR_WIDTH bits, the framebuffer word address.
REQ-011 The module SHALL have port fb_rdata, input, 32 bits, the framebuffer read data, with the pixel colour in bits [11:0] as {R[11:8],G[7:4],B[3:0]}.
REQ-012 The module SHALL have ports vga_r, vga_g and vga_b, outputs, 4 bits each, the colour channels.
REQ-013 The module SHALL have ports vga_hs and vga_vs, outputs, 1 bit each, the syncs, active-low.
REQ-014 The module SHALL have port frame_start, output, 1 bit, a single-clk pulse at the start of each frame.

Function
REQ-015 h_cnt SHALL count 0..H_TOT-1, with H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800), and SHALL advance only on clk edges where pix_ce=1.
REQ-016 h_cnt SHALL wrap from H_TOT-1 to 0, and v_cnt SHALL increment on that same tick.
REQ-017 v_cnt SHALL count 0..V_TOT-1, with V_TOT = 525, and SHALL wrap to 0 when h_cnt and v_cnt are both at their maxima.
REQ-018 The block SHALL treat a position as active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-019 On each pix_ce cycle at an active position, fb_re SHALL be 1 for exactly that clk.
REQ-020 On that same clk, fb_raddr SHALL be (v_cnt>>SCALE_SHIFT)*FB_W + (h_cnt>>SCALE_SHIFT), truncated to `DISP_ADDR_WIDTH bits.
REQ-021 fb_re SHALL be 0 at all other times; fb_raddr SHALL hold its last value when fb_re=0.
REQ-022 The block SHALL treat fb_rdata as valid exactly 1 clk after fb_re, and SHALL capture bits [11:0] into a pixel hold register on that clk.
REQ-023 The block SHALL ignore bits [31:12] of fb_rdata.
REQ-024 Outputs SHALL be registered and updated only on pix_ce, so the output at tick k+1 reflects the counter position (h,v) of tick k: a fixed one-pixel-tick latency.
REQ-025 For a position that was active, vga_r/g/b SHALL equal the held pixel; otherwise vga_r/g/b SHALL be 0.
REQ-026 vga_hs SHALL be 0 iff the delayed h lies in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
REQ-027 vga_vs SHALL be 0 iff the delayed v lies in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491].
REQ-028 frame_start SHALL be 1 for exactly one clk, on the pix_ce cycle in which the counters are (0,0).
REQ-029 When pix_ce=0, all counters, outputs and the delay stage SHALL hold, with no drift.
REQ-030 Each horizontal pixel SHALL be emitted 2^SCALE_SHIFT times and each line repeated 2^SCALE_SHIFT times; no read SHALL be issued for a position whose address falls outside the active area.

Reset
REQ-031 On a clk edge with reset=1, the block SHALL set h_cnt=0, v_cnt=0, fb_re=0, fb_raddr=0, the pixel hold register to 0, vga_r/g/b=0, vga_hs=1, vga_vs=1 and frame_start=0.
REQ-032 Reset SHALL take priority over pix_ce.
REQ-033 A reset asserted mid-frame SHALL abandon the frame, and a read in flight SHALL be discarded.
REQ-034 The first pix_ce after reset release SHALL be treated as position (0,0): frame_start=1 and fb_re=1 with fb_raddr=0.

Verification
REQ-035 Reset then pix_ce every 4th clk -> the first tick gives frame_start=1, fb_re=1, fb_raddr=0; one full frame gives exactly 800*525 ticks between frame_start pulses.
REQ-036 Framebuffer model returning 12'hF00 at every address -> vga_r=4'hF, vga_g=vga_b=0 for all 640x480 active outputs, and rgb=0 on all other ticks.
REQ-037 At line 0, a count of vga_hs low ticks per line -> exactly 96, starting at the 657th output tick of the line; vga_vs is low for exactly 2 lines (490,491).
REQ-038 Tick at (h=5,v=3) with SCALE_SHIFT=1 -> fb_raddr=1*320+2=322; h=4 and h=5 both read address 322.
REQ-039 Hold pix_ce=0 for 100 clk mid-line -> no output or counter changes and fb_re=0 throughout; resuming continues from the same position.
REQ-040 Assert reset during line 200 -> the next clk shows rgb=0, hs=vs=1; after release, frame_start fires on the first tick.
